// File: rtl/toggle_cover_pkg.sv
// Shared types and helpers for the toggle-coverage scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package toggle_cover_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Bits needed to address 'total' items; never narrower than one bit.
    function automatic int idx_w(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    // Global cover index of group 'grp', bit 'bitn'.
    function automatic int unsigned cover_idx(input int unsigned base,
                                              input int unsigned width,
                                              input int unsigned grp,
                                              input int unsigned bitn);
        return base + grp * width + bitn;
    endfunction

endpackage

// File: rtl/toggle_cover_rr_pick.sv
// Round-robin group pick plus lowest-set-bit encoder over the pending bitmap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the grant.
//
// Ports:
//   pending     in  per-group pending bitmap (group g = pending[g*GROUP_WIDTH +: GROUP_WIDTH])
//   rr          in  group to search first
//   grant_valid out any pending bit exists
//   grant_group out winning group
//   grant_bit   out lowest pending bit within the winning group
module toggle_cover_rr_pick #(
    parameter int NUM_GROUPS  = 4,
    parameter int GROUP_WIDTH = 29,
    parameter int GRP_W       = 2,
    parameter int BIT_W       = 5
) (
    input  logic [NUM_GROUPS*GROUP_WIDTH-1:0] pending,
    input  logic [GRP_W-1:0]                  rr,
    output logic                              grant_valid,
    output logic [GRP_W-1:0]                  grant_group,
    output logic [BIT_W-1:0]                  grant_bit
);

    logic [GROUP_WIDTH-1:0] sel;

    function automatic int wrap_grp(input int g);
        return (g >= NUM_GROUPS) ? g - NUM_GROUPS : g;
    endfunction

    always_comb begin
        grant_valid = 1'b0;
        grant_group = '0;
        grant_bit   = '0;
        sel         = '0;
        // Scan from farthest to nearest so the group closest to rr wins last.
        for (int k = NUM_GROUPS - 1; k >= 0; k--) begin
            if (|pending[wrap_grp(int'(rr) + k) * GROUP_WIDTH +: GROUP_WIDTH]) begin
                grant_valid = 1'b1;
                grant_group = GRP_W'(wrap_grp(int'(rr) + k));
            end
        end
        sel = pending[int'(grant_group) * GROUP_WIDTH +: GROUP_WIDTH];
        for (int b = GROUP_WIDTH - 1; b >= 0; b--) begin
            if (sel[b]) grant_bit = BIT_W'(b);
        end
    end

endmodule

// File: rtl/toggle_cover_sched.sv
// Latches first toggle hits per cover point and serializes new global indices round-robin over groups.
// Latency: hit to out_valid is 2 cycles minimum; back-to-back one index per cycle while ready.
// Backpressure: out_index/out_valid hold until out_ready; hits keep being captured meanwhile.
//
// Ports:
//   clock, reset   clock and synchronous active-high reset
//   valid          per-group toggle hits this cycle
//   clear          pulse: forget all hit/pending state (deferred until the held index is accepted)
//   out_valid/out_ready/out_index  report channel
//   hit_count      distinct indices reported since reset/clear, saturating
//   busy           pending work, a held index, or a clear in progress
module toggle_cover_sched
    import toggle_cover_pkg::*;
#(
    parameter  int NUM_GROUPS  = 4,
    parameter  int GROUP_WIDTH = 29,
    parameter  int COVER_INDEX = 0,
    parameter  int COVER_TOTAL = 8065,
    localparam int IDX_W       = idx_w(COVER_TOTAL)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_GROUPS*GROUP_WIDTH-1:0] valid,
    input  logic                              clear,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [IDX_W-1:0]                  out_index,
    output logic [IDX_W:0]                    hit_count,
    output logic                              busy
);

    localparam int NB    = NUM_GROUPS * GROUP_WIDTH;
    localparam int GRP_W = idx_w(NUM_GROUPS);
    localparam int BIT_W = idx_w(GROUP_WIDTH);

    state_t            state, state_nxt;
    logic [NB-1:0]     seen, pending, grant_mask;
    logic [GRP_W-1:0]  rr;
    logic              clear_req;
    logic              grant_valid;
    logic [GRP_W-1:0]  grant_group;
    logic [BIT_W-1:0]  grant_bit;
    logic              load, hs, wipe;

    toggle_cover_rr_pick #(
        .NUM_GROUPS  (NUM_GROUPS),
        .GROUP_WIDTH (GROUP_WIDTH),
        .GRP_W       (GRP_W),
        .BIT_W       (BIT_W)
    ) u_pick (
        .pending     (pending),
        .rr          (rr),
        .grant_valid (grant_valid),
        .grant_group (grant_group),
        .grant_bit   (grant_bit)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        hs        = 1'b0;
        wipe      = 1'b0;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt = CLEAR;
                    wipe      = 1'b1;
                end else if (grant_valid) begin
                    state_nxt = HOLD;
                    load      = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    hs = 1'b1;
                    // A clear seen while holding waits for this handshake, then wins over reloading.
                    if (clear_req || clear) begin
                        state_nxt = CLEAR;
                    end else if (grant_valid) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            CLEAR: begin
                state_nxt = IDLE;
                wipe      = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_mask = '0;
        if (load) grant_mask[int'(grant_group) * GROUP_WIDTH + int'(grant_bit)] = 1'b1;
    end

    assign out_valid = (state == HOLD);
    assign busy      = (|pending) || out_valid || (state == CLEAR);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            seen      <= '0;
            pending   <= '0;
            rr        <= '0;
            clear_req <= 1'b0;
            out_index <= '0;
            hit_count <= '0;
        end else begin
            state <= state_nxt;
            if (wipe) begin
                seen      <= '0;
                pending   <= '0;
                hit_count <= '0;
            end else begin
                seen <= seen | valid;
                // New hits are added after the select, so they only compete from the next cycle on.
                pending <= (pending & ~grant_mask) | (valid & ~seen);
                if (hs && hit_count != '1) hit_count <= hit_count + (IDX_W+1)'(1);
            end
            if (load) begin
                out_index <= IDX_W'(cover_idx(COVER_INDEX, GROUP_WIDTH,
                                              int'(grant_group), int'(grant_bit)));
                rr        <= (grant_group == GRP_W'(NUM_GROUPS - 1)) ? '0
                                                                     : grant_group + GRP_W'(1);
            end
            if (state_nxt == CLEAR) begin
                clear_req <= 1'b0;
            end else if (state == HOLD && clear) begin
                clear_req <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_toggle_cover_sched.sv
module tb_toggle_cover_sched;

    localparam int NG = 4;
    localparam int GW = 29;
    localparam int NB = NG * GW;
    localparam int CI = 100;
    localparam int CT = 8065;
    localparam int IW = 13;

    logic          clock = 1'b0;
    logic          reset, clear, out_ready;
    logic [NB-1:0] valid;
    logic          out_valid, busy;
    logic [IW-1:0] out_index;
    logic [IW:0]   hit_count;

    always #5 clock = ~clock;

    toggle_cover_sched #(
        .NUM_GROUPS  (NG),
        .GROUP_WIDTH (GW),
        .COVER_INDEX (CI),
        .COVER_TOTAL (CT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .valid     (valid),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .hit_count (hit_count),
        .busy      (busy)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    bit m_seen[NB];
    bit m_pend[NB];
    int m_rr, m_idx, m_cnt;
    bit m_hold, m_clearing, m_creq;
    int reports[$];

    function automatic bit any_pend();
        for (int i = 0; i < NB; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_wipe();
        for (int i = 0; i < NB; i++) begin m_seen[i] = 0; m_pend[i] = 0; end
        m_cnt = 0;
    endtask

    // Round-robin: first group from m_rr with anything pending, lowest bit in it.
    task automatic m_load();
        for (int k = 0; k < NG; k++) begin
            int g;
            g = (m_rr + k) % NG;
            for (int b = 0; b < GW; b++) begin
                if (m_pend[g*GW + b]) begin
                    m_idx = CI + g*GW + b;
                    m_pend[g*GW + b] = 0;
                    m_rr = (g + 1) % NG;
                    return;
                end
            end
        end
    endtask

    task automatic m_step(input logic [NB-1:0] v, input bit c, input bit r, input bit rst);
        if (rst) begin
            m_wipe();
            m_rr = 0; m_idx = 0; m_hold = 0; m_clearing = 0; m_creq = 0;
            return;
        end
        if (m_clearing) begin
            m_wipe();
            m_clearing = 0;
            m_creq = 0;
            return;
        end
        if (!m_hold) begin
            if (c) begin
                m_wipe();
                m_clearing = 1;
                return;
            end
            if (any_pend()) begin
                m_load();
                m_hold = 1;
            end
        end else if (r) begin
            if (m_cnt < (1 << (IW + 1)) - 1) m_cnt++;
            if (m_creq || c) begin
                m_hold = 0; m_clearing = 1; m_creq = 0;
            end else if (any_pend()) begin
                m_load();
            end else begin
                m_hold = 0;
            end
        end else if (c) begin
            m_creq = 1;
        end
        for (int i = 0; i < NB; i++) begin
            if (v[i] && !m_seen[i]) m_pend[i] = 1;
            if (v[i]) m_seen[i] = 1;
        end
    endtask

    task automatic compare();
        chk("out_valid", out_valid, m_hold);
        chk("busy", busy, any_pend() || m_hold || m_clearing);
        chk("hit_count", hit_count, m_cnt);
        if (m_hold) chk("out_index", out_index, m_idx);
    endtask

    // One clock: drive at the falling edge, step the model, check at the next falling edge.
    task automatic cycle(input logic [NB-1:0] v, input bit c, input bit r);
        valid = v; clear = c; out_ready = r;
        if (!reset && out_valid && r) reports.push_back(int'(out_index));
        m_step(v, c, r, reset);
        @(posedge clock);
        @(negedge clock);
        compare();
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle('0, 1'b0, r);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2, 1'b0);
        reset = 1'b0;
    endtask

    function automatic logic [NB-1:0] hb(input int g, input int b);
        logic [NB-1:0] v;
        v = '0;
        v[g*GW + b] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [NB-1:0] v;
        int held, n107, uniq, dups;
        bit done;
        bit got[NB];

        reset = 1'b1; clear = 1'b0; out_ready = 1'b0; valid = '0;
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_index", out_index, 0);
        chk("rst_count", hit_count, 0);
        chk("rst_busy", busy, 0);

        // Single hit: two-cycle latency to out_valid.
        cycle(hb(1, 3), 1'b0, 1'b1);
        chk("t1_valid_early", out_valid, 0);
        cycle('0, 1'b0, 1'b1);
        chk("t1_valid", out_valid, 1);
        chk("t1_index", out_index, 132);
        cycle('0, 1'b0, 1'b1);
        chk("t1_count", hit_count, 1);

        // Dedup: held high, then pulsed again.
        reports.delete();
        for (int i = 0; i < 10; i++) cycle(hb(0, 7), 1'b0, 1'b1);
        idle(3, 1'b1);
        cycle(hb(0, 7), 1'b0, 1'b1);
        idle(3, 1'b1);
        n107 = 0;
        foreach (reports[i]) if (reports[i] == 107) n107++;
        chk("t2_reports", n107, 1);
        chk("t2_count", hit_count, 2);

        // Fairness across groups, one per cycle.
        do_reset();
        reports.delete();
        cycle(hb(0, 0) | hb(0, 1) | hb(2, 5) | hb(3, 0), 1'b0, 1'b1);
        idle(6, 1'b1);
        chk("t3_n", reports.size(), 4);
        if (reports.size() == 4) begin
            chk("t3_r0", reports[0], 100);
            chk("t3_r1", reports[1], 163);
            chk("t3_r2", reports[2], 187);
            chk("t3_r3", reports[3], 101);
        end

        // Backpressure then release.
        reports.delete();
        cycle(hb(1, 0) | hb(1, 1) | hb(3, 28), 1'b0, 1'b0);
        idle(20, 1'b0);
        chk("t4_held", out_valid, 1);
        idle(3, 1'b1);
        chk("t4_n", reports.size(), 3);
        chk("t4_busy", busy, 0);

        // Clear while holding.
        do_reset();
        reports.delete();
        cycle(hb(2, 2) | hb(3, 3), 1'b0, 1'b0);
        idle(1, 1'b0);
        held = m_idx;
        cycle('0, 1'b1, 1'b0);
        idle(4, 1'b0);
        chk("t5_still_valid", out_valid, 1);
        cycle('0, 1'b0, 1'b1);
        chk("t5_count_one", hit_count, 1);
        chk("t5_accepted", reports.size(), 1);
        idle(1, 1'b1);
        chk("t5_count_zero", hit_count, 0);
        chk("t5_busy", busy, 0);
        reports.delete();
        cycle(hb((held - CI) / GW, (held - CI) % GW), 1'b0, 1'b1);
        idle(4, 1'b1);
        chk("t5_rehit_n", reports.size(), 1);
        if (reports.size() == 1) chk("t5_rehit_idx", reports[0], held);

        // Reset mid-hold.
        cycle(hb(1, 9) | hb(2, 9), 1'b0, 1'b0);
        idle(2, 1'b0);
        reset = 1'b1;
        idle(1, 1'b0);
        reset = 1'b0;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_busy", busy, 0);

        // All bits at once, random ready.
        reports.delete();
        cycle('1, 1'b0, 1'b0);
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            cycle('0, 1'b0, 1'($urandom_range(1)));
            done = !m_hold && !any_pend() && !m_clearing;
        end
        chk("t6_drained", done, 1);
        uniq = 0; dups = 0;
        foreach (reports[i]) begin
            if (reports[i] < CI || reports[i] >= CI + NB) dups++;
            else if (got[reports[i] - CI]) dups++;
            else begin got[reports[i] - CI] = 1'b1; uniq++; end
        end
        chk("t6_unique", uniq, NB);
        chk("t6_dups", dups, 0);
        chk("t6_count", hit_count, NB);

        // Random sparse hits, random ready, occasional clears.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            v = '0;
            if ($urandom_range(3) == 0)
                repeat ($urandom_range(3, 1)) v[$urandom_range(NB - 1)] = 1'b1;
            cycle(v, ($urandom_range(63) == 0), 1'($urandom_range(2) != 0));
        end
        idle(300, 1'b1);
        chk("rand_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
